// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads instruction words, resolves one level of indirection, and issues IR/AR/I to execute.
// One-cycle memory latency; issue after 4 cycles (direct) or 6 (indirect); outputs held stable until instr_ready.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [11:0] mem_address,
  output logic        mem_write_enable,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] ir_out,
  output logic [11:0] ar_out,
  output logic        i_out,
  output logic [11:0] pc_out,
  input  logic        pc_load,
  input  logic [11:0] pc_in,
  input  logic        halt,
  output logic        halted
);

  typedef enum logic [2:0] {
    F_REQ  = 3'd0,
    F_CAP  = 3'd1,
    DECODE = 3'd2,
    I_REQ  = 3'd3,
    I_CAP  = 3'd4,
    ISSUE  = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] pc;
  logic [11:0] ar;
  logic [15:0] ir;
  logic        ind;
  logic        xfer;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= F_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    xfer        = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    mem_address = pc;
    case (state)
      F_REQ:  state_nxt = F_CAP;
      F_CAP:  state_nxt = DECODE;
      // Register-reference opcode (111) carries I=1 but never dereferences memory.
      DECODE: state_nxt = (ir[15] && (ir[14:12] != 3'b111)) ? I_REQ : ISSUE;
      I_REQ: begin
        mem_address = ar;
        state_nxt   = I_CAP;
      end
      I_CAP: begin
        mem_address = ar;
        state_nxt   = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          xfer      = 1'b1;
          state_nxt = halt ? STOP : F_REQ;
        end
      end
      STOP:    halted = 1'b1;
      default: state_nxt = F_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= RESET_PC;
      ir  <= 16'h0000;
      ar  <= 12'h000;
      ind <= 1'b0;
    end else begin
      case (state)
        F_CAP: begin
          ir <= mem_data;
          pc <= pc + 12'd1;
        end
        DECODE: begin
          ar  <= ir[11:0];
          ind <= ir[15];
        end
        I_CAP: ar <= mem_data[11:0];
        // Halt wins over a simultaneous redirect, leaving PC untouched.
        ISSUE: if (xfer && !halt && pc_load) pc <= pc_in;
        default: ;
      endcase
    end
  end

  assign mem_write_enable = 1'b0;
  assign ir_out           = ir;
  assign ar_out           = ar;
  assign i_out            = ind;
  assign pc_out           = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios push expected issues into a scoreboard; a monitor checks every issue.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] mem_address;
  logic        mem_write_enable;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] ir_out;
  logic [11:0] ar_out;
  logic        i_out;
  logic [11:0] pc_out;
  logic        pc_load = 1'b0;
  logic [11:0] pc_in = 12'h000;
  logic        halt = 1'b0;
  logic        halted;

  logic        reset1_n = 1'b0;
  logic [11:0] mem_address1;
  logic        mem_write_enable1;
  logic [15:0] mem_data1;
  logic        instr_valid1;
  logic        instr_ready1 = 1'b1;
  logic [15:0] ir_out1;
  logic [11:0] ar_out1;
  logic        i_out1;
  logic [11:0] pc_out1;
  logic        pc_load1 = 1'b1;
  logic [11:0] pc_in1 = 12'h555;
  logic        halt1 = 1'b1;
  logic        halted1;

  logic [15:0] mem [0:4095];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt = 0;
  logic        we_seen = 1'b0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [15:0] ir;
    logic [11:0] ar;
    logic        i;
    logic [11:0] pc;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ir_out(ir_out),
    .ar_out(ar_out), .i_out(i_out), .pc_out(pc_out), .pc_load(pc_load),
    .pc_in(pc_in), .halt(halt), .halted(halted)
  );

  fetch_unit #(.RESET_PC(12'hFFF)) dut1 (
    .clock(clock), .reset_n(reset1_n), .mem_address(mem_address1),
    .mem_write_enable(mem_write_enable1), .mem_data(mem_data1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready1), .ir_out(ir_out1),
    .ar_out(ar_out1), .i_out(i_out1), .pc_out(pc_out1), .pc_load(pc_load1),
    .pc_in(pc_in1), .halt(halt1), .halted(halted1)
  );

  always #5 clock = ~clock;

  // Memory with one cycle of read latency.
  always @(posedge clock) begin
    mem_data  <= mem[mem_address];
    mem_data1 <= mem[mem_address1];
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  always @(negedge clock) begin
    if (mem_write_enable !== 1'b0 || mem_write_enable1 !== 1'b0) we_seen <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic [11:0] ar, input logic i,
                      input logic [11:0] pc, input int cyc);
    exp_t x;
    x.ir = ir; x.ar = ar; x.i = i; x.pc = pc; x.cyc = cyc;
    sb.push_back(x);
  endtask

  // Lands 1 time unit after the falling edge inside cycle n (cycle 1 ends at the first edge after release).
  task automatic at_cycle(input int n);
    do @(negedge clock); while (cnt + 1 < n);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, checks issue cycle, stall stability and contents.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset_n) begin
        prev_valid = 1'b0;
      end else begin
        if (instr_valid) begin
          if (sb.size() == 0) begin
            if (!prev_valid) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_issue: ir %h at cycle %0d, none expected", ir_out, cnt + 1);
            end
          end else begin
            e = sb[0];
            if (!prev_valid) chk("issue_cycle", cnt + 1, e.cyc);
            chk("ir_out", {16'h0, ir_out}, {16'h0, e.ir});
            chk("ar_out", {20'h0, ar_out}, {20'h0, e.ar});
            chk("i_out", {31'h0, i_out}, {31'h0, e.i});
            chk("pc_out", {20'h0, pc_out}, {20'h0, e.pc});
            if (instr_ready) void'(sb.pop_front());
          end
        end
        prev_valid = instr_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_pc", {20'h0, pc_out}, 32'h000);
    chk("rst_ir", {16'h0, ir_out}, 32'h0000);
    chk("rst_addr", {20'h0, mem_address}, 32'h000);

    // Direct instructions back to back, then halt on the third
    mem[0] = 16'h2005; mem[1] = 16'h3007; mem[2] = 16'h7001;
    instr_ready = 1'b1; halt = 1'b0;
    push(16'h2005, 12'h005, 1'b0, 12'h001, 4);
    push(16'h3007, 12'h007, 1'b0, 12'h002, 8);
    push(16'h7001, 12'h001, 1'b0, 12'h003, 12);
    release_reset();
    at_cycle(1);
    chk("s1_freq_addr", {20'h0, mem_address}, 32'h000);
    at_cycle(9);
    halt = 1'b1;
    at_cycle(13);
    chk("s1_halted", {31'h0, halted}, 32'h1);
    chk("s1_pc_stop", {20'h0, pc_out}, 32'h003);

    // Indirect fetch; halt held high throughout is ignored until the transfer
    do_reset();
    mem[0] = 16'hA00F; mem[12'h00F] = 16'h0123;
    push(16'hA00F, 12'h123, 1'b1, 12'h001, 6);
    release_reset();
    at_cycle(4);
    chk("s2_ireq_addr", {20'h0, mem_address}, 32'h00F);
    at_cycle(5);
    chk("s2_icap_addr", {20'h0, mem_address}, 32'h00F);
    at_cycle(7);
    chk("s2_halted", {31'h0, halted}, 32'h1);

    // Register-reference with I=1: no indirect access
    do_reset();
    mem[0] = 16'hF800;
    push(16'hF800, 12'h800, 1'b1, 12'h001, 4);
    release_reset();
    at_cycle(3);
    chk("s3_decode_addr", {20'h0, mem_address}, 32'h001);
    at_cycle(5);
    chk("s3_halted", {31'h0, halted}, 32'h1);

    // Backpressure and redirect, with a stray redirect pulse during F_CAP
    do_reset();
    mem[0] = 16'h2005; mem[12'h040] = 16'h1234;
    instr_ready = 1'b0; halt = 1'b0;
    push(16'h2005, 12'h005, 1'b0, 12'h001, 4);
    push(16'h1234, 12'h234, 1'b0, 12'h041, 13);
    release_reset();
    at_cycle(2);
    pc_load = 1'b1; pc_in = 12'h0AA;
    at_cycle(3);
    pc_load = 1'b0;
    at_cycle(9);
    instr_ready = 1'b1; pc_load = 1'b1; pc_in = 12'h040;
    at_cycle(10);
    chk("s4_redirect_addr", {20'h0, mem_address}, 32'h040);
    chk("s4_redirect_pc", {20'h0, pc_out}, 32'h040);
    pc_load = 1'b0; halt = 1'b1;
    at_cycle(14);
    chk("s4_halted", {31'h0, halted}, 32'h1);

    // PC wrap from FFF and halt taking priority over redirect (second instance)
    mem[12'hFFF] = 16'h4ABC;
    @(posedge clock);
    #1 reset1_n = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    chk("s5_valid", {31'h0, instr_valid1}, 32'h1);
    chk("s5_ir", {16'h0, ir_out1}, 32'h4ABC);
    chk("s5_ar", {20'h0, ar_out1}, 32'hABC);
    chk("s5_pc_wrap", {20'h0, pc_out1}, 32'h000);
    repeat (3) @(negedge clock);
    #1;
    chk("s5_halted", {31'h0, halted1}, 32'h1);
    chk("s5_valid_stop", {31'h0, instr_valid1}, 32'h0);
    chk("s5_pc_stop", {20'h0, pc_out1}, 32'h000);

    // Async reset during I_CAP, then a clean refetch
    do_reset();
    mem[0] = 16'hA00F; mem[12'h00F] = 16'h0123;
    instr_ready = 1'b1; halt = 1'b1;
    release_reset();
    at_cycle(5);
    chk("s6_icap_addr", {20'h0, mem_address}, 32'h00F);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_ar", {20'h0, ar_out}, 32'h000);
    chk("s6_rst_ir", {16'h0, ir_out}, 32'h0000);
    chk("s6_rst_i", {31'h0, i_out}, 32'h0);
    chk("s6_rst_pc", {20'h0, pc_out}, 32'h000);
    chk("s6_rst_addr", {20'h0, mem_address}, 32'h000);
    chk("s6_rst_valid", {31'h0, instr_valid}, 32'h0);
    push(16'hA00F, 12'h123, 1'b1, 12'h001, 6);
    release_reset();
    at_cycle(1);
    chk("s6_refetch_addr", {20'h0, mem_address}, 32'h000);
    at_cycle(7);
    chk("s6_halted", {31'h0, halted}, 32'h1);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 32'h0);
    chk("write_enable_never", {31'h0, we_seen}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
